// File: rtl/axi_mem_slave.sv
// Simple AXI-style memory slave with fixed-length bursts of 64-bit words.
// Independent read and write engines share one word-addressed storage array.
module axi_mem_slave #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ar_addr,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [63:0] r_data,
  input  logic [31:0] aw_addr,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [63:0] w_data,
  input  logic        w_valid,
  output logic        w_ready
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAST_BEAT = 4'(BEATS - 1);
  localparam logic [3:0]  LAST_WAIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_t;

  logic [63:0]      mem [MEM_WORDS];

  r_state_t         r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_idx_nxt;
  logic [3:0]       r_beat;
  logic [3:0]       r_wait;

  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_beat;

  logic [IDX_W-1:0] ar_idx;
  logic [IDX_W-1:0] aw_idx;
  logic             w_fire;
  logic             addr_unused;

  // Byte address to word index; low three bits and bits above the array size are dropped.
  always_comb begin
    ar_idx    = ar_addr[3 +: IDX_W];
    aw_idx    = aw_addr[3 +: IDX_W];
    r_idx_nxt = r_idx + IDX_W'(1);
    w_fire    = (w_state == W_DATA) && w_valid && w_ready;
  end

  assign addr_unused = ^{ar_addr[31:IDX_W+3], ar_addr[2:0],
                         aw_addr[31:IDX_W+3], aw_addr[2:0]};

  // Read engine: accept address, wait RD_LAT cycles, then stream BEATS words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_idx    <= '0;
      r_beat   <= '0;
      r_wait   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_valid && ar_ready) begin
            r_idx    <= ar_idx;
            r_beat   <= '0;
            r_wait   <= '0;
            ar_ready <= 1'b0;
            if (RD_LAT == 0) begin
              r_state <= R_DATA;
              r_valid <= 1'b1;
              r_data  <= mem[ar_idx];
            end else begin
              r_state <= R_WAIT;
            end
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_wait == LAST_WAIT) begin
            r_state <= R_DATA;
            r_valid <= 1'b1;
            r_data  <= mem[r_idx];
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        R_DATA: begin
          if (r_valid && r_ready) begin
            r_idx <= r_idx_nxt;
            if (r_beat == LAST_BEAT) begin
              r_state  <= R_IDLE;
              r_valid  <= 1'b0;
              r_beat   <= '0;
              ar_ready <= 1'b1;
            end else begin
              r_beat <= r_beat + 4'd1;
              r_data <= mem[r_idx_nxt];
            end
          end
        end
        default: begin
          r_state  <= R_IDLE;
          r_valid  <= 1'b0;
          ar_ready <= 1'b0;
        end
      endcase
    end
  end

  // Write engine: accept address, then take exactly BEATS data words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      w_idx    <= '0;
      w_beat   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          w_ready <= 1'b0;
          if (aw_valid && aw_ready) begin
            w_state  <= W_DATA;
            w_idx    <= aw_idx;
            w_beat   <= '0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
          end else begin
            aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + IDX_W'(1);
            if (w_beat == LAST_BEAT) begin
              w_state  <= W_IDLE;
              w_beat   <= '0;
              w_ready  <= 1'b0;
              aw_ready <= 1'b1;
            end else begin
              w_beat <= w_beat + 4'd1;
            end
          end
        end
        default: begin
          w_state  <= W_IDLE;
          w_ready  <= 1'b0;
          aw_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage update; reads above sample the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      mem[w_idx] <= w_data;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: one instance with default latency, one with RD_LAT=0.
module tb_axi_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        sel;

  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        r_ready;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic [63:0] w_data;
  logic        w_valid;

  logic        ar_ready0, r_valid0, aw_ready0, w_ready0;
  logic [63:0] r_data0;
  logic        ar_ready1, r_valid1, aw_ready1, w_ready1;
  logic [63:0] r_data1;

  logic        ar_valid0, r_ready0, aw_valid0, w_valid0;
  logic        ar_valid1, r_ready1, aw_valid1, w_valid1;

  logic        ar_ready_s, r_valid_s, aw_ready_s, w_ready_s;
  logic [63:0] r_data_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign ar_valid0 = ar_valid & ~sel;
  assign r_ready0  = r_ready  & ~sel;
  assign aw_valid0 = aw_valid & ~sel;
  assign w_valid0  = w_valid  & ~sel;
  assign ar_valid1 = ar_valid &  sel;
  assign r_ready1  = r_ready  &  sel;
  assign aw_valid1 = aw_valid &  sel;
  assign w_valid1  = w_valid  &  sel;

  assign ar_ready_s = sel ? ar_ready1 : ar_ready0;
  assign r_valid_s  = sel ? r_valid1  : r_valid0;
  assign aw_ready_s = sel ? aw_ready1 : aw_ready0;
  assign w_ready_s  = sel ? w_ready1  : w_ready0;
  assign r_data_s   = sel ? r_data1   : r_data0;

  axi_mem_slave #(.MEM_WORDS(1024), .BEATS(2), .RD_LAT(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ar_addr(ar_addr), .ar_valid(ar_valid0), .ar_ready(ar_ready0),
    .r_valid(r_valid0), .r_ready(r_ready0), .r_data(r_data0),
    .aw_addr(aw_addr), .aw_valid(aw_valid0), .aw_ready(aw_ready0),
    .w_data(w_data), .w_valid(w_valid0), .w_ready(w_ready0)
  );

  axi_mem_slave #(.MEM_WORDS(1024), .BEATS(2), .RD_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ar_addr(ar_addr), .ar_valid(ar_valid1), .ar_ready(ar_ready1),
    .r_valid(r_valid1), .r_ready(r_ready1), .r_data(r_data1),
    .aw_addr(aw_addr), .aw_valid(aw_valid1), .aw_ready(aw_ready1),
    .w_data(w_data), .w_valid(w_valid1), .w_ready(w_ready1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Starts and ends on a falling edge; checks handshake timing along the way.
  task automatic wr_burst(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1);
    int n;
    logic [63:0] d [2];
    d[0] = d0;
    d[1] = d1;
    aw_addr  = addr;
    aw_valid = 1'b1;
    n = 0;
    while (!aw_ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_handshake_bound", 64'(n < 20), 64'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    chk("wr_aw_ready_busy", 64'(aw_ready_s), 64'd0);
    chk("wr_w_ready_open", 64'(w_ready_s), 64'd1);
    for (int i = 0; i < 2; i++) begin
      w_data  = d[i];
      w_valid = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        chk("wr_w_ready_mid", 64'(w_ready_s), 64'd1);
        chk("wr_aw_ready_mid", 64'(aw_ready_s), 64'd0);
      end
    end
    w_valid = 1'b0;
    chk("wr_w_ready_done", 64'(w_ready_s), 64'd0);
    chk("wr_aw_ready_done", 64'(aw_ready_s), 64'd1);
  endtask

  // lat counts falling edges from the handshake cycle to the first valid beat.
  task automatic rd_burst(input logic [31:0] addr, input int stall,
                          output logic [63:0] d0, output logic [63:0] d1, output int lat);
    int n;
    ar_addr  = addr;
    ar_valid = 1'b1;
    r_ready  = (stall == 0);
    n = 0;
    while (!ar_ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_handshake_bound", 64'(n < 20), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    lat = 1;
    while (!r_valid_s && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("r_valid_bound", 64'(lat < 40), 64'd1);
    d0 = r_data_s;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_r_valid_held", 64'(r_valid_s), 64'd1);
      chk("bp_r_data_held", r_data_s, d0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    chk("rd_beat2_valid", 64'(r_valid_s), 64'd1);
    d1 = r_data_s;
    @(negedge clk);
    r_ready = 1'b0;
    chk("rd_done_r_valid", 64'(r_valid_s), 64'd0);
    chk("rd_done_ar_ready", 64'(ar_ready_s), 64'd1);
  endtask

  typedef struct {
    logic        do_wr;
    logic [31:0] wa;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [31:0] ra;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [63:0] g0, g1;
    int          lat;

    rst_n = 1'b0; sel = 1'b0;
    ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
    aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_valid = 1'b0;

    tbl[0] = '{1'b1, 32'h0000_0020, 64'hA0A0_0000_0000_0001, 64'hB0B0_0000_0000_0002,
               32'h0000_0020, 64'hA0A0_0000_0000_0001, 64'hB0B0_0000_0000_0002};
    tbl[1] = '{1'b1, 32'h0000_1FF8, 64'hC0C0_1111_2222_3333, 64'hD0D0_4444_5555_6666,
               32'h0000_1FF8, 64'hC0C0_1111_2222_3333, 64'hD0D0_4444_5555_6666};
    tbl[2] = '{1'b1, 32'h0000_0007, 64'hE0E0_7777_8888_9999, 64'hF0F0_AAAA_BBBB_CCCC,
               32'h0000_0000, 64'hE0E0_7777_8888_9999, 64'hF0F0_AAAA_BBBB_CCCC};
    tbl[3] = '{1'b0, 32'h0000_0000, 64'h0, 64'h0,
               32'h0000_1FFC, 64'hC0C0_1111_2222_3333, 64'hE0E0_7777_8888_9999};
    tbl[4] = '{1'b1, 32'h1234_5030, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               32'h0000_1030, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ar_ready", 64'(ar_ready0), 64'd0);
    chk("rst_aw_ready", 64'(aw_ready0), 64'd0);
    chk("rst_w_ready", 64'(w_ready0), 64'd0);
    chk("rst_r_valid", 64'(r_valid0), 64'd0);
    chk("rst_r_data", r_data0, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ar_ready_before_edge", 64'(ar_ready0), 64'd0);
    @(negedge clk);
    chk("rel_ar_ready", 64'(ar_ready0), 64'd1);
    chk("rel_aw_ready", 64'(aw_ready0), 64'd1);

    // Write burst then timed read-back
    wr_burst(32'h8000_0010, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
    rd_burst(32'h8000_0010, 0, g0, g1, lat);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_beat1", g0, 64'h1111_1111_1111_1111);
    chk("rd_beat2", g1, 64'h2222_2222_2222_2222);

    // Backpressure on the first beat
    rd_burst(32'h8000_0010, 5, g0, g1, lat);
    chk("bp_beat1", g0, 64'h1111_1111_1111_1111);
    chk("bp_beat2", g1, 64'h2222_2222_2222_2222);

    // Table: write/read pairs including wrap, low-bit and high-bit aliasing
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].do_wr) wr_burst(tbl[i].wa, tbl[i].w0, tbl[i].w1);
      rd_burst(tbl[i].ra, 0, g0, g1, lat);
      chk($sformatf("tbl%0d_beat1", i), g0, tbl[i].e0);
      chk($sformatf("tbl%0d_beat2", i), g1, tbl[i].e1);
    end

    // w_valid while idle must not touch storage (the stale write index would be word 6)
    wr_burst(32'h0000_0030, 64'h6666_0000_0000_0006, 64'h7777_0000_0000_0007);
    wr_burst(32'h0000_0020, 64'h4444_0000_0000_0004, 64'h5555_0000_0000_0005);
    w_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_w_ready", 64'(w_ready0), 64'd0);
    end
    w_valid = 1'b0;
    rd_burst(32'h0000_0028, 0, g0, g1, lat);
    chk("idle_w_word5", g0, 64'h5555_0000_0000_0005);
    chk("idle_w_word6", g1, 64'h6666_0000_0000_0006);

    // Zero-latency instance: concurrent AR/AW
    sel = 1'b1;
    @(negedge clk);
    wr_burst(32'h0000_0038, 64'h0707_0707_0707_0707, 64'h0808_0808_0808_0808);
    wr_burst(32'h0000_0048, 64'h0909_0909_0909_0909, 64'h1010_1010_1010_1010);
    rd_burst(32'h0000_0038, 0, g0, g1, lat);
    chk("z_latency", 64'(lat), 64'd1);
    chk("z_pre_word7", g0, 64'h0707_0707_0707_0707);

    ar_addr = 32'h0000_0040; aw_addr = 32'h0000_0040;
    ar_valid = 1'b1; aw_valid = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    ar_valid = 1'b0; aw_valid = 1'b0;
    chk("conc_r_valid", 64'(r_valid1), 64'd1);
    chk("conc_beat1_old", r_data1, 64'h0808_0808_0808_0808);
    w_data = 64'h8888_8888_0000_0008; w_valid = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    chk("conc_beat2_old", r_data1, 64'h0909_0909_0909_0909);
    w_data = 64'h9999_9999_0000_0009;
    @(negedge clk);
    w_valid = 1'b0; r_ready = 1'b0;
    chk("conc_r_done", 64'(r_valid1), 64'd0);
    chk("conc_aw_ready", 64'(aw_ready1), 64'd1);
    rd_burst(32'h0000_0040, 0, g0, g1, lat);
    chk("conc_commit8", g0, 64'h8888_8888_0000_0008);
    chk("conc_commit9", g1, 64'h9999_9999_0000_0009);

    // Read loads word 8 on the same edge that writes word 8
    ar_addr = 32'h0000_0038; aw_addr = 32'h0000_0040;
    ar_valid = 1'b1; aw_valid = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    ar_valid = 1'b0; aw_valid = 1'b0;
    chk("rbw_beat1", r_data1, 64'h0707_0707_0707_0707);
    w_data = 64'hAAAA_0000_0000_0008; w_valid = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    chk("rbw_beat2_prewrite", r_data1, 64'h8888_8888_0000_0008);
    w_data = 64'hAAAA_0000_0000_0009;
    @(negedge clk);
    w_valid = 1'b0; r_ready = 1'b0;
    rd_burst(32'h0000_0040, 0, g0, g1, lat);
    chk("rbw_commit8", g0, 64'hAAAA_0000_0000_0008);
    chk("rbw_commit9", g1, 64'hAAAA_0000_0000_0009);

    // Reset in the middle of a read burst
    sel = 1'b0;
    @(negedge clk);
    ar_addr = 32'h8000_0010; ar_valid = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    lat = 1;
    while (!r_valid0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_mid_r_valid_bound", 64'(lat < 40), 64'd1);
    @(negedge clk);
    chk("rst_mid_beat2_pending", 64'(r_valid0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_r_valid_async", 64'(r_valid0), 64'd0);
    chk("rst_mid_ar_ready", 64'(ar_ready0), 64'd0);
    r_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_rel_ar_ready_pre", 64'(ar_ready0), 64'd0);
    @(negedge clk);
    chk("rst_mid_rel_ar_ready", 64'(ar_ready0), 64'd1);
    chk("rst_mid_rel_r_valid", 64'(r_valid0), 64'd0);
    r_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_more_beats", 64'(r_valid0), 64'd0);
    r_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning number of 64-bit storage words (power of two).
REQ-002 SHALL have parameter BEATS, default 2, meaning fixed beats per read or write burst (1..16).
REQ-003 SHALL have parameter RD_LAT, default 2, meaning idle cycles between AR handshake and the first r_valid (0..15).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous assert, active-low.
REQ-006 SHALL have port ar_addr, input, 32 bits, meaning read burst start byte address.
REQ-007 SHALL have port ar_valid, input, 1 bit, meaning read address valid.
REQ-008 SHALL have port ar_ready, output, 1 bit, meaning read address accepted.
REQ-009 SHALL have port r_valid, output, 1 bit, meaning read data beat valid.
REQ-010 SHALL have port r_ready, input, 1 bit, meaning master accepts read beat.
REQ-011 SHALL have port r_data, output, 64 bits, meaning read beat data.
REQ-012 SHALL have port aw_addr, input, 32 bits, meaning write burst start byte address.
REQ-013 SHALL have port aw_valid, input, 1 bit, meaning write address valid.
REQ-014 SHALL have port aw_ready, output, 1 bit, meaning write address accepted.
REQ-015 SHALL have port w_data, input, 64 bits, meaning write beat data (full 64-bit writes, no strobe).
REQ-016 SHALL have port w_valid, input, 1 bit, meaning write beat valid.
REQ-017 SHALL have port w_ready, output, 1 bit, meaning write beat accepted.

Function
REQ-018 SHALL map byte address to word index addr[2:0] ignored, index = addr[3 +: log2(MEM_WORDS)]; higher bits ignored (aliasing).
REQ-019 SHALL increment the word index by 1 per beat, wrapping modulo MEM_WORDS.
REQ-020 SHALL run the read FSM with states R_IDLE, R_WAIT, R_DATA.
REQ-021 SHALL in R_IDLE drive ar_ready=1; on ar_valid&&ar_ready latch index, clear beat counter, go R_WAIT (or R_DATA when RD_LAT=0).
REQ-022 SHALL in R_WAIT count RD_LAT cycles with ar_ready=0, r_valid=0, then go R_DATA.
REQ-023 SHALL register r_data from storage at the entry to R_DATA and at each accepted non-final beat, holding r_data and r_valid stable while r_ready=0.
REQ-024 SHALL on r_valid&&r_ready advance index and beat counter; after beat BEATS return to R_IDLE with r_valid=0 next cycle.
REQ-025 SHALL run the write FSM with states W_IDLE, W_DATA, independent of the read FSM.
REQ-026 SHALL in W_IDLE drive aw_ready=1, w_ready=0; on aw_valid&&aw_ready latch index, clear beat counter, go W_DATA.
REQ-027 SHALL in W_DATA drive w_ready=1; each w_valid&&w_ready writes w_data to storage at the current index and advances; after beat BEATS return to W_IDLE.
REQ-028 SHALL give a read beat loaded in the same cycle as a write to the same index the pre-write value (read-before-write).
REQ-029 SHALL ignore w_valid while in W_IDLE (no write, no buffering).
REQ-030 SHALL allow AR and AW handshakes in the same cycle; both proceed concurrently.
REQ-031 SHALL leave storage contents uninitialised by reset (simulation may preload).

Reset
REQ-032 SHALL on rst_n=0 asynchronously force R_IDLE, W_IDLE, counters 0, r_valid=0, r_data=0, ar_ready=0, aw_ready=0, w_ready=0.
REQ-033 SHALL drive ar_ready=1 and aw_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-034 SHALL abandon any burst on reset mid-operation; partially written beats remain in storage, and no further beats are emitted.

Verification
REQ-035 Write burst: AW 0x80000010, W beats 0x11..11, 0x22..22 -> words 2,3 updated; aw_ready=0 and w_ready=1 for exactly 2 accepted beats, then aw_ready=1.
REQ-036 Read-back, RD_LAT=2: AR 0x80000010 at cycle T -> r_valid rises T+3, r_data 0x11..11 then 0x22..22, ar_ready=1 again after beat 2.
REQ-037 Backpressure: r_ready=0 for 5 cycles during beat 1 -> r_valid and r_data held constant, no beat skipped.
REQ-038 Wrap: MEM_WORDS=1024, AR 0x00001FF8 -> beat 1 from word 1023, beat 2 from word 0.
REQ-039 Concurrent: AR and AW to the same address in the same cycle, RD_LAT=0 -> first read beat returns the old value, and the write commits.
REQ-040 Reset mid-read after beat 1 -> r_valid=0 immediately and asynchronously, and ar_ready=1 after the first clk edge following release.
